hdmi_wave_render: RTL
=====================

# hdmi_wave_render

Pixel renderer between the 1080p HDMI timing generator and the HDMI transmitter pins. It consumes the generator's h_sync/v_sync/data_en stream and buffers one screen-width of captured audio samples in a double-buffered line memory. It replaces the constant fill colour with an oscilloscope-style waveform trace, and forwards the sync and enable signals delay-matched to the rendered pixel data.

## Interface
- H_ACTIVE, 1920, active pixels per line; sample buffer depth per bank
- V_ACTIVE, 1080, active lines per frame
- CENTER_ROW, 539, row drawn for a zero-valued sample
- FG_COLOR, 24'h00FF00, trace colour
- BG_COLOR, 24'h000000, background colour

- clk  in  1  pixel clock, 148.5 MHz; same clock as the timing generator
- rst  in  1  asynchronous, active-high reset
- in_h_sync  in  1  horizontal sync from the timing generator
- in_v_sync  in  1  vertical sync from the timing generator
- in_data_en  in  1  active-video enable from the timing generator
- s_valid  in  1  audio sample valid
- s_data  in  16  signed audio sample
- s_ready  out  1  write bank can accept a sample
- data  out  24  RGB pixel, {R,G,B}
- h_sync  out  1  in_h_sync delayed 2 cycles
- v_sync  out  1  in_v_sync delayed 2 cycles
- data_en  out  1  in_data_en delayed 2 cycles

## Operation
- Two banks of H_ACTIVE x 11-bit entries. Each entry holds a row index: row = CENTER_ROW - (s_data >>> 6). Arithmetic shift gives -512..511, so row is 28..1051. Compute the row in 12-bit signed, then store the 11 LSBs.
- Write side: wr_ptr (11 bit) is written into the write bank on s_valid && s_ready, then wr_ptr increments. s_ready = (wr_ptr < H_ACTIVE). When the bank is full, s_ready is low and s_valid is ignored; the source holds.
- Swap: on the rising edge of in_v_sync (registered compare against the previous value):
  - If wr_ptr == H_ACTIVE, the banks swap, wr_ptr clears to 0, and disp_valid is set.
  - Otherwise there is no swap and writing continues.
  - If the final write and the v_sync rising edge occur in the same cycle, the write lands first, the bank counts as full, and the swap occurs.
- Read side:
  - x (11 bit) increments each cycle in_data_en is high and clears on the cycle in_data_en is low. It saturates at H_ACTIVE-1.
  - y (11 bit) increments on each falling edge of in_data_en and clears on the rising edge of in_v_sync. It saturates at V_ACTIVE-1.
- Pipeline:
  - Stage 1 is a registered read of the display bank at address x.
  - Stage 2 compares the read value against y (delayed 1 cycle) and selects the colour.
- Colour rule: data = FG_COLOR when disp_valid && en_d2 && (row == y_d1); otherwise BG_COLOR when en_d2, else 0.
- State: no explicit FSM. The state is bank_sel, wr_ptr, disp_valid, x, y, and the 2-stage delay line.

## Timing
- Latency from in_* to the outputs is exactly 2 clk cycles. Sync, enable and data stay mutually aligned.
- Reset values:
  - data=0, h_sync=0, v_sync=0, data_en=0, s_ready=1 (wr_ptr=0).
  - disp_valid=0, bank_sel=0, x=0, y=0, and the delay line is all 0.
- Reset asserted mid-frame: all state clears immediately (asynchronously). The first frame after reset renders BG only until the first swap.
- The bank swap takes effect on the cycle after the v_sync rising edge. That edge falls during vertical blanking, so no active pixel ever mixes the two banks.
- Memory read/write collision is impossible because the banks are always disjoint.

## Configuration
- WAVE_FILL_EN defined: a pixel is FG when y lies between CENTER_ROW and row inclusive, in either order. The result is a filled envelope.
- WAVE_FILL_EN undefined: a pixel is FG only when row == y, giving a single-pixel trace.

## Test plan
- Reset mid-frame, then release: all outputs are 0 during reset. After release, s_ready=1 and data_en pixels are BG_COLOR until the first swap.
- Write 1920 samples of 0, then drive a v_sync rising edge: the next frame shows FG_COLOR only on row 539, across all 1920 columns. Without WAVE_FILL_EN, rows 538 and 540 are BG.
- Write s_data=16'h7FC0 at column 0 and 0 elsewhere, then swap: column 0 shows FG at row 28 (539-511) and the rest of row 539 is FG. With WAVE_FILL_EN, column 0 is FG on rows 28..539.
- Write 1000 samples, then drive a v_sync rising edge: there is no swap, disp_valid stays 0, and s_ready stays 1. Write 920 more so that sample 1920 coincides with the v_sync rising edge: the swap occurs and wr_ptr clears to 0.
- Hold s_valid=1 after the bank is full: s_ready=0, wr_ptr holds at 1920, and no entry is overwritten.
- Compare delays against the input: h_sync, v_sync and data_en equal the inputs delayed by exactly 2 cycles for a full 2200x1125 frame.

Source files
------------

// File: rtl/hdmi_wave_render.sv
// hdmi_wave_render: oscilloscope-style waveform renderer for the 1080p HDMI path.
// Captured audio samples are converted to screen rows and stored in a
// double-buffered line memory. One bank is drawn while the other one fills.
// The sync and enable signals are forwarded with a 2-cycle delay so that they
// stay aligned with the pixel data.
// Optional feature: define WAVE_FILL_EN to draw a filled envelope between the
// centre row and the sample row. Without it, the trace is a single pixel high.
module hdmi_wave_render #(
    parameter int          H_ACTIVE   = 1920,
    parameter int          V_ACTIVE   = 1080,
    parameter int          CENTER_ROW = 539,
    parameter logic [23:0] FG_COLOR   = 24'h00FF00,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_h_sync,
    input  logic        in_v_sync,
    input  logic        in_data_en,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic [23:0] data,
    output logic        h_sync,
    output logic        v_sync,
    output logic        data_en
);

    localparam int         AW     = $clog2(H_ACTIVE);
    localparam logic [10:0] H_FULL = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] CENTER = 11'(CENTER_ROW);

    // bank_sel_q names the bank being displayed; the other bank is written
    logic [10:0] bank0_mem [H_ACTIVE];
    logic [10:0] bank1_mem [H_ACTIVE];

    logic [10:0] wr_ptr_q, wr_ptr_d;
    logic        bank_sel_q, bank_sel_d;
    logic        disp_valid_q, disp_valid_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        vs_prev_q;
    logic        en_prev_q;

    logic [10:0] rd_row_q;
    logic [10:0] y_d1_q;
    logic        en_d1_q, hs_d1_q, vs_d1_q;

    logic [23:0] data_q, data_d;
    logic        hs_d2_q, vs_d2_q, en_d2_q;

    logic        wr_fire;
    logic        vs_rise;
    logic        en_fall;
    logic [10:0] wr_row;
    logic        row_hit;

    assign s_ready = (wr_ptr_q < H_FULL);
    assign wr_fire = s_valid && s_ready;
    assign vs_rise = in_v_sync && !vs_prev_q;
    assign en_fall = en_prev_q && !in_data_en;

    // Row is worked out in 12-bit signed arithmetic; only the low 11 bits are stored
    assign wr_row = 11'(12'(CENTER_ROW) - 12'($signed(s_data) >>> 6));

    // Write pointer, bank swap and display-valid next state; a write that lands
    // in the same cycle as the v_sync edge still counts towards a full bank
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        bank_sel_d   = bank_sel_q;
        disp_valid_d = disp_valid_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 11'd1;
        end
        if (vs_rise && (wr_ptr_d == H_FULL)) begin
            wr_ptr_d     = '0;
            bank_sel_d   = ~bank_sel_q;
            disp_valid_d = 1'b1;
        end
    end

    // Raster position: x counts active pixels in the line, y counts finished lines
    always_comb begin
        x_d = '0;
        if (in_data_en) begin
            x_d = (x_q == H_LAST) ? x_q : x_q + 11'd1;
        end
        y_d = y_q;
        if (vs_rise) begin
            y_d = '0;
        end else if (en_fall && (y_q != V_LAST)) begin
            y_d = y_q + 11'd1;
        end
    end

    // Control and raster state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            bank_sel_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            vs_prev_q    <= 1'b0;
            en_prev_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            bank_sel_q   <= bank_sel_d;
            disp_valid_q <= disp_valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vs_prev_q    <= in_v_sync;
            en_prev_q    <= in_data_en;
        end
    end

    // Sample store into whichever bank is not on screen
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (bank_sel_q) begin
                bank0_mem[wr_ptr_q[AW-1:0]] <= wr_row;
            end else begin
                bank1_mem[wr_ptr_q[AW-1:0]] <= wr_row;
            end
        end
    end

    // Stage 1: registered read of the display bank, with syncs and y carried along
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_row_q <= '0;
            y_d1_q   <= '0;
            en_d1_q  <= 1'b0;
            hs_d1_q  <= 1'b0;
            vs_d1_q  <= 1'b0;
        end else begin
            rd_row_q <= bank_sel_q ? bank1_mem[x_q[AW-1:0]] : bank0_mem[x_q[AW-1:0]];
            y_d1_q   <= y_q;
            en_d1_q  <= in_data_en;
            hs_d1_q  <= in_h_sync;
            vs_d1_q  <= in_v_sync;
        end
    end

`ifdef WAVE_FILL_EN
    // Filled envelope: hit when y lies between the centre row and the sample row
    always_comb begin
        row_hit = 1'b0;
        if (rd_row_q <= CENTER) begin
            row_hit = (y_d1_q >= rd_row_q) && (y_d1_q <= CENTER);
        end else begin
            row_hit = (y_d1_q >= CENTER) && (y_d1_q <= rd_row_q);
        end
    end
`else
    // Single-pixel trace: hit only on the sample row itself
    always_comb begin
        row_hit = (rd_row_q == y_d1_q);
    end
`endif

    // Stage 2 colour select: trace colour on a hit once a bank is valid, else background
    always_comb begin
        data_d = '0;
        if (en_d1_q) begin
            data_d = (disp_valid_q && row_hit) ? FG_COLOR : BG_COLOR;
        end
    end

    // Stage 2 output registers keep pixel, syncs and enable aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            hs_d2_q <= 1'b0;
            vs_d2_q <= 1'b0;
            en_d2_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            hs_d2_q <= hs_d1_q;
            vs_d2_q <= vs_d1_q;
            en_d2_q <= en_d1_q;
        end
    end

    assign data    = data_q;
    assign h_sync  = hs_d2_q;
    assign v_sync  = vs_d2_q;
    assign data_en = en_d2_q;

endmodule
